// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory it feeds.
package imem_loader_pkg;

  localparam int INSTR_W    = 32;
  localparam int LEN_W      = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } ldr_state_e;

  // States in which the loader advertises in_ready.
  function automatic logic accepts_bytes(input ldr_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid is combinational with the 4th byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk0,
  input  logic               clear,
  input  logic               take,
  input  logic [7:0]         byte_in,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word_dat
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (take) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_valid = take && !clear && (cnt_q == 2'd3);
  assign word_dat   = {shift_q, byte_in};

  always_ff @(posedge clk0) begin
    shift_q <= shift_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory from word 0 while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic               clk0,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [INSTR_W-1:0] mem_wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LEN_W-1:0]   words_loaded
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH);

  ldr_state_e         state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_new;
  logic               xfer, start_go, take, word_valid;
  logic [INSTR_W-1:0] word_dat;

  assign xfer    = in_valid && in_ready_q;
  assign len_new = {len_q[15:8], in_data};
  // Bytes arriving in the final write cycle are beyond the programmed length.
  assign take    = (state_q == ST_DATA) && xfer && (words_q != len_q);

  imem_word_packer u_packer (
    .clk0       (clk0),
    .clear      (!reset || start_go),
    .take       (take),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word_dat   (word_dat)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = err_q;
    words_d   = words_q;
    len_d     = len_q;
    start_go  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = ST_LEN_HI;
          words_d  = '0;
          err_d    = 1'b0;
          hold_d   = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == '0) begin
            state_d = ST_DONE;
          end else if ({1'b0, len_new} > DEPTH_L) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (words_q == len_q) begin
          state_d = ST_DONE;
        end else if (word_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q[ADDR_W-1:0];
          wr_data_d = word_dat;
          words_d   = words_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = accepts_bytes(state_d);
  end

  always_ff @(posedge clk0) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      len_q      <= len_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign cpu_hold     = hold_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs driven and outputs sampled on the falling edge.
module tb_imem_loader;

  logic        clk0 = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_wr_en, cpu_hold, busy, done, error;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  logic [9:0]  wa [0:7];
  logic [31:0] wd [0:7];

  imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk0(clk0), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk0 = ~clk0;

  // Write recorder: every strobe seen on a falling edge is logged.
  always @(negedge clk0) begin
    if (mem_wr_en) begin
      if (wr_cnt < 8) begin
        wa[wr_cnt] = mem_wr_addr;
        wd[wr_cnt] = mem_wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk0);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(negedge clk0);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk0);
    checks++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_hold, busy, done, error, words_loaded} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b wl=%0d required all 0",
               in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_hold, busy, done, error, words_loaded);
    end
    reset = 1'b1;
    @(negedge clk0);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b rdy=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic(input bit stall);
    int n, hold_bad, spur;
    logic [7:0] w0 [0:3];
    logic [7:0] w1 [0:3];
    w0 = '{8'h20, 8'h08, 8'h00, 8'h05};
    w1 = '{8'h00, 8'h85, 8'h30, 8'h20};
    wr_cnt = 0;
    spur = 0;
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL start_state hold=%b busy=%b rdy=%b required 1 1 1", cpu_hold, busy, in_ready);
    end
    send_byte(8'h00); send_byte(8'h02);
    for (int i = 0; i < 4; i++) begin
      send_byte(w0[i]);
      if (stall && i == 1) begin
        repeat (3) begin
          if (mem_wr_en !== 1'b0 || in_ready !== 1'b1) spur++;
          @(negedge clk0);
        end
      end
    end
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'd0 || mem_wr_data !== 32'h20080005 || words_loaded !== 16'd1) begin
      failures++;
      $display("FAIL write0 stall=%0b we=%b a=%0d d=%h wl=%0d required 1 0 20080005 1",
               stall, mem_wr_en, mem_wr_addr, mem_wr_data, words_loaded);
    end
    for (int i = 0; i < 4; i++) send_byte(w1[i]);
    checks++;
    if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'd1 || mem_wr_data !== 32'h00853020 || words_loaded !== 16'd2) begin
      failures++;
      $display("FAIL write1 stall=%0b we=%b a=%0d d=%h wl=%0d required 1 1 00853020 2",
               stall, mem_wr_en, mem_wr_addr, mem_wr_data, words_loaded);
    end
    n = 0; hold_bad = 0;
    while (!done && n < 10) begin
      if (cpu_hold !== 1'b1) hold_bad++;
      @(negedge clk0);
      n++;
    end
    checks++;
    if (n !== 2 || hold_bad !== 0 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
      failures++;
      $display("FAIL done_timing stall=%0b cycles=%0d hold_drops=%0d hold=%b wl=%0d required 2 0 0 2",
               stall, n, hold_bad, cpu_hold, words_loaded);
    end
    @(negedge clk0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_cnt !== 2 || spur !== 0) begin
      failures++;
      $display("FAIL post_done stall=%0b done=%b busy=%b writes=%0d stall_glitches=%0d required 0 0 2 0",
               stall, done, busy, wr_cnt, spur);
    end
  endtask

  task automatic test_zero_len();
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL zero_len_early done=%b required 0", done);
    end
    @(negedge clk0);
    checks++;
    if (done !== 1'b1 || words_loaded !== 16'd0 || cpu_hold !== 1'b0 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL zero_len done=%b wl=%0d hold=%b writes=%0d required 1 0 0 0", done, words_loaded, cpu_hold, wr_cnt);
    end
    @(negedge clk0);
  endtask

  task automatic test_len_err();
    int n;
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    repeat (3) @(negedge clk0);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1 || wr_cnt !== 0) begin
      failures++;
      $display("FAIL len_err err=%b rdy=%b hold=%b busy=%b writes=%0d required 1 0 1 1 0",
               error, in_ready, cpu_hold, busy, wr_cnt);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL err_restart err=%b rdy=%b required 0 1", error, in_ready);
    end
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    n = 0;
    while (!done && n < 10) begin @(negedge clk0); n++; end
    checks++;
    if (!done || wr_cnt !== 1 || wa[0] !== 10'd0 || wd[0] !== 32'hDEADBEEF || error !== 1'b0) begin
      failures++;
      $display("FAIL err_reload done=%b writes=%0d a=%0d d=%h err=%b required 1 1 0 deadbeef 0",
               done, wr_cnt, wa[0], wd[0], error);
    end
    @(negedge clk0);
  endtask

  task automatic test_reset_mid();
    int n;
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2);
    reset = 1'b0;
    @(negedge clk0);
    checks++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_hold, busy, done, error, words_loaded} !== '0
        || wr_cnt !== 1 || wa[0] !== 10'd0 || wd[0] !== 32'hA1A2A3A4) begin
      failures++;
      $display("FAIL reset_mid rdy=%b we=%b a=%h d=%h hold=%b busy=%b wl=%0d writes=%0d w0=%h required zeros, 1 write a1a2a3a4",
               in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_hold, busy, words_loaded, wr_cnt, wd[0]);
    end
    reset = 1'b1;
    @(negedge clk0);
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    n = 0;
    while (!done && n < 10) begin @(negedge clk0); n++; end
    checks++;
    if (!done || wr_cnt !== 1 || wa[0] !== 10'd0 || wd[0] !== 32'h11223344 || words_loaded !== 16'd1) begin
      failures++;
      $display("FAIL reload_after_reset done=%b writes=%0d a=%0d d=%h wl=%0d required 1 1 0 11223344 1",
               done, wr_cnt, wa[0], wd[0], words_loaded);
    end
    @(negedge clk0);
  endtask

  task automatic test_start_in_data();
    int n;
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hCA); send_byte(8'hFE);
    pulse_start();
    @(negedge clk0);
    checks++;
    if (words_loaded !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b1 || mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored wl=%0d rdy=%b busy=%b we=%b required 0 1 1 0", words_loaded, in_ready, busy, mem_wr_en);
    end
    send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    n = 0;
    while (!done && n < 10) begin @(negedge clk0); n++; end
    checks++;
    if (!done || wr_cnt !== 2 || wa[0] !== 10'd0 || wd[0] !== 32'hCAFEF00D
        || wa[1] !== 10'd1 || wd[1] !== 32'h12345678 || words_loaded !== 16'd2) begin
      failures++;
      $display("FAIL start_in_data done=%b writes=%0d w0=%0d:%h w1=%0d:%h wl=%0d required 1 2 0:cafef00d 1:12345678 2",
               done, wr_cnt, wa[0], wd[0], wa[1], wd[1], words_loaded);
    end
    @(negedge clk0);
  endtask

  initial begin
    @(negedge clk0);
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_zero_len();
    test_len_err();
    test_reset_mid();
    test_start_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program writer for the calculator's instruction memory; the write-side counterpart to the PC-driven fetch path that reads it.
- Accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words and writes them to consecutive word addresses starting at 0.
- Holds the CPU in reset while loading, so programs load in-system rather than only via simulation preload.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 1024, number of instruction words; must be ≤ 2**ADDR_W.

Ports:
- clk0  in  1  module clock; same slow clock as the CPU core.
- reset  in  1  synchronous, active-low reset (already decided).
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_wr_en  out  1  one-cycle instruction memory write strobe.
- mem_wr_addr  out  ADDR_W  word address of the write.
- mem_wr_data  out  32  instruction word.
- cpu_hold  out  1  hold CPU in reset; OR'd into the core reset.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky length error; cleared by reset or start.
- words_loaded  out  16  count of words written this session.

Behaviour:
- Reset (reset==0 at a clk0 edge):
  - State → IDLE.
  - All outputs 0: in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, cpu_hold, busy, done, error, words_loaded.
  - Byte counter, shift register and length register cleared.
  - A partial word is discarded; no write is issued.
- Transfer: a byte transfers when in_valid && in_ready at a rising clk0 edge. in_ready is registered and depends only on state.
- States:
  - IDLE: in_ready=0, cpu_hold=0. On start → LEN_HI; clear words_loaded, error and byte counter; set cpu_hold=1.
  - LEN_HI: in_ready=1. On transfer, len[15:8] ← byte → LEN_LO.
  - LEN_LO: in_ready=1. On transfer, len[7:0] ← byte, then:
    - len==0 → DONE.
    - len>DEPTH → ERR.
    - otherwise → DATA.
  - DATA: in_ready=1.
    - Bytes arrive MSB first: word = {b0,b1,b2,b3}. Shift register holds the partial word; 2-bit byte counter.
    - On the 4th transfer, mem_wr_data, mem_wr_addr and mem_wr_en=1 are registered, so the write appears one cycle after the 4th byte is accepted.
    - mem_wr_en is high for exactly one cycle. words_loaded increments in that same cycle; mem_wr_addr = words_loaded before the increment.
    - in_ready stays high during the write cycle, so back-to-back streaming runs at 1 byte/cycle.
    - When words_loaded reaches len (the cycle after the last write) → DONE.
  - DONE: done=1 for one cycle, cpu_hold drops to 0 the same cycle → IDLE.
  - ERR: in_ready=0, error=1, cpu_hold=1, no writes. start → LEN_HI with error cleared.
- start outside IDLE/ERR is ignored.
- in_data while in_ready=0 is ignored; no buffering.
- Address never wraps: len ≤ DEPTH guarantees mem_wr_addr ≤ DEPTH-1.
- busy = (state != IDLE).
- Stalls: in_valid may drop at any point, including mid-word; the partial word and counter are held indefinitely.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared calc package holds:
  - Loader state encoding: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR.
  - INSTR_W=32.
  - Default ADDR_W and DEPTH, shared with the instruction memory.
- One sub-module: imem_word_packer.
  - 8→32 shift register with byte counter.
  - Emits word_valid when the 4th byte is accepted.
  - Has its own clear input, driven on start and reset.

Test Plan:
- Stream 00 02 | 20 08 00 05 | 00 85 30 20, in_valid always high, after start.
  - Writes addr0=32'h20080005, then addr1=32'h00853020.
  - Each write lands one cycle after its 4th byte.
  - done pulses; words_loaded=2; cpu_hold high from the cycle after start until done.
- Same stream with in_valid low for 3 cycles after byte b1 of word 0.
  - Identical writes; no spurious mem_wr_en during the stall.
- Length 00 00.
  - No writes; done pulses two cycles after the LEN_LO byte; words_loaded=0.
- Length 04 01 (1025 > DEPTH).
  - ERR: error=1, in_ready=0, cpu_hold=1, zero writes.
  - A subsequent start with length 00 01 and word DEADBEEF writes addr0=32'hDEADBEEF and clears error.
- reset=0 after 2 bytes of word 1 in a 3-word load.
  - Only addr0 written; all outputs 0 next cycle.
  - Re-load completes normally from addr0.
- start pulsed during DATA.
  - Ignored: counters and addresses unchanged, load completes normally.
